// File: rtl/clk_div_4.sv
// Divide-by-4 clock generator: a phase bit plus a registered output level, 50% duty.
// Optional tick_o strobe on each clk_o rising transition when CLK_DIV_4_TICK_EN is defined.
`timescale 1ns/1ps
module clk_div_4 #(
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   output logic clk_o
`ifdef CLK_DIV_4_TICK_EN
   ,
   output logic tick_o
`endif
);

   logic p_q, p_d;
   logic clk_q, clk_d;

   always_comb begin
      p_d   = ~p_q;
      // Output flips on every second edge, when the phase bit is set.
      clk_d = clk_q ^ p_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q   <= 1'b0;
         clk_q <= RESET_LEVEL;
      end else begin
         p_q   <= p_d;
         clk_q <= clk_d;
      end
   end

   assign clk_o = clk_q;

`ifdef CLK_DIV_4_TICK_EN
   logic tick_q, tick_d;

   always_comb begin
      tick_d = ~clk_q & p_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_4.sv
// Self-checking bench for clk_div_4: directed timing checks, a 100-cycle free run and
// randomized asynchronous reset pulses, against an edge-count reference model.
`timescale 1ns/1ps
module tb_clk_div_4;

   logic clk;
   logic rst;
   logic clk0, clk1;
`ifdef CLK_DIV_4_TICK_EN
   logic tick0, tick1;
`endif

   int checks   = 0;
   int failures = 0;
   int n        = 0;  // rising clk edges since the last reset release

   clk_div_4 #(.RESET_LEVEL(1'b0)) u_dut0 (
      .clk   (clk),
      .rst   (rst),
      .clk_o (clk0)
`ifdef CLK_DIV_4_TICK_EN
      ,
      .tick_o(tick0)
`endif
   );

   clk_div_4 #(.RESET_LEVEL(1'b1)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .clk_o (clk1)
`ifdef CLK_DIV_4_TICK_EN
      ,
      .tick_o(tick1)
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) n <= 0;
      else      n <= n + 1;
   end

   // Level holds for edges 0,1 then inverts for edges 2,3, repeating every 4 edges.
   function automatic logic exp_clk(input logic rl, input int k);
      return rl ^ logic'((k / 2) % 2);
   endfunction

   function automatic logic exp_tick(input logic rl, input int k);
      if (k < 1) return 1'b0;
      return exp_clk(rl, k) && !exp_clk(rl, k - 1);
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_clk_rl0"}, clk0, exp_clk(1'b0, n));
      chk({tag, "_clk_rl1"}, clk1, exp_clk(1'b1, n));
`ifdef CLK_DIV_4_TICK_EN
      chk({tag, "_tick_rl0"}, tick0, rst ? exp_tick(1'b0, n) : 1'b0);
      chk({tag, "_tick_rl1"}, tick1, rst ? exp_tick(1'b1, n) : 1'b0);
`endif
   endtask

   task automatic chk_int(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs == exp)
      else begin
         failures++;
         $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
      end
   endtask

   initial begin
      logic   prev;
      bit     have_last;
      time    last_t;
      int     rises, ticks;
      int     run, off, width;

      rst = 1'b0;
      #20;
      check_all("reset_hold");
      chk("reset_lvl0", clk0, 1'b0);
      chk("reset_lvl1", clk1, 1'b1);
      #15 rst = 1'b1;                   // t=35, between edges 30 and 50
      #34 check_all("pre_first_rise");  // t=69
      chk("t69_low", clk0, 1'b0);
      #2  check_all("first_rise");      // t=71
      chk("t71_high", clk0, 1'b1);
      chk("t71_rl1_low", clk1, 1'b0);
      #38 chk("t109_high", clk0, 1'b1);
      #2  chk("t111_low", clk0, 1'b0);
      check_all("first_fall");
      #40 chk("t151_high", clk0, 1'b1);
      check_all("second_rise");

      // Asynchronous reset mid-cycle while clk_o is high.
      #14 rst = 1'b0;                   // t=165
      #1  chk("async_rst_rl0", clk0, 1'b0);
      chk("async_rst_rl1", clk1, 1'b1);
      check_all("async_rst");
      #9  rst = 1'b1;                   // t=175
      #34 chk("restart_low", clk0, 1'b0);   // t=209
      #2  chk("restart_high", clk0, 1'b1);  // t=211
      check_all("restart");

      // Free run for 100 cycles after a fresh release.
      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      prev = clk0;
      have_last = 1'b0;
      last_t = 0;
      rises = 0;
      ticks = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         check_all("free_run");
         if (clk0 !== prev) begin
            if (have_last) chk_int("interval_ns", longint'($time - last_t), 40);
            have_last = 1'b1;
            last_t = $time;
            if (clk0 === 1'b1) rises++;
         end
         prev = clk0;
`ifdef CLK_DIV_4_TICK_EN
         if (tick0 === 1'b1) ticks++;
`endif
      end
      chk_int("rise_count", rises, 25);
`ifdef CLK_DIV_4_TICK_EN
      chk_int("tick_count", ticks, rises);
`endif

      // Random run lengths with short asynchronous reset pulses inside one clk period.
      for (int i = 0; i < 30; i++) begin
         run = $urandom_range(1, 12);
         repeat (run) begin
            @(posedge clk);
            #1 check_all("rand_run");
         end
         off = $urandom_range(2, 9);
         width = $urandom_range(1, 7);
         #(off - 1) rst = 1'b0;
         #1 check_all("rand_rst");
         chk("rand_rst_rl0", clk0, 1'b0);
         #(width) rst = 1'b1;
      end
      repeat (6) begin
         @(posedge clk);
         #1 check_all("tail");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_div_4.md
CLK_DIV_4 -- requirements
Module: clk_div_4

Interface
REQ-001 Parameter: RESET_LEVEL, default 1'b0, level driven on clk_o while reset is asserted; also the starting phase after release.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-low (asserted when 0).
REQ-004 Port: clk_o  output  1  divided clock at one quarter of the clk frequency, 50% duty.
REQ-005 Port (only with CLK_DIV_4_TICK_EN): tick_o  output  1  one-clk-cycle strobe marking each clk_o rising transition.

Function
REQ-006 Internal state SHALL be one phase bit (p) plus the registered clk_o level; no combinational path from any input to clk_o.
REQ-007 On every rising clk edge with reset deasserted: p <= ~p; clk_o <= clk_o XOR p (evaluated with pre-edge values).
REQ-008 clk_o SHALL therefore hold each level for exactly 2 clk cycles: period 4 clk cycles, duty exactly 50%.
REQ-009 With RESET_LEVEL=0, the first clk_o 0->1 transition SHALL occur on the 2nd rising clk edge after reset release; subsequent transitions every 2 edges.
REQ-010 With RESET_LEVEL=1, the sequence SHALL be the complement: first 1->0 transition on the 2nd rising edge after release.
REQ-011 clk_o SHALL be driven directly from a flip-flop (glitch-free, usable as a derived clock).
REQ-012 The divider SHALL free-run indefinitely; no enable, no terminal state, phase bit wraps 1->0 naturally.
REQ-013 Reset asserted mid-period SHALL immediately abort the current phase; no partial period is completed.

Reset
REQ-014 Assertion of rst (0) SHALL asynchronously force p=0 and clk_o=RESET_LEVEL, independent of clk.
REQ-015 tick_o (when present) SHALL be 0 during reset.
REQ-016 Deassertion SHALL take effect at the next rising clk edge; the first edge after release counts as edge 1 for REQ-009.
REQ-017 Reset pulses shorter than one clk period SHALL still fully reset the state.

Configuration
REQ-018 Macro CLK_DIV_4_TICK_EN: when defined, port tick_o exists and is a registered strobe high for exactly one clk cycle starting at the edge where clk_o goes 0->1 (i.e., tick_o <= ~clk_o & p), once per 4 cycles.
REQ-019 When CLK_DIV_4_TICK_EN is undefined, tick_o and its logic SHALL be absent; clk_o behaviour SHALL be identical in both builds.

Verification
REQ-020 clk period 20 ns, rst=0 from t=0 to t=30 ns, then 1 -> clk_o=0 throughout reset; rises at 2nd posedge after release (t=70 ns), falls t=110, rises t=150.
REQ-021 Free run for 100 clk cycles after reset -> exactly 25 clk_o rising edges; every high and low interval exactly 40 ns.
REQ-022 Assert rst asynchronously mid-cycle while clk_o=1 (e.g., t=85 ns) -> clk_o goes to 0 within the same time step without waiting for clk; after release the sequence restarts per REQ-020 timing.
REQ-023 RESET_LEVEL=1 -> clk_o=1 during reset, first fall at 2nd posedge after release, then period 4 cycles.
REQ-024 CLK_DIV_4_TICK_EN defined -> tick_o high for exactly one clk cycle coincident with the first clk cycle of each clk_o high phase; never high during reset; count equals clk_o rising-edge count.
